// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low digit patterns, blank code and readback FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG7_PAT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

    typedef enum logic {
        WAIT_FIRST = 1'b0,
        RUN        = 1'b1
    } seg7_rb_state_t;

endpackage

// File: rtl/seg7_to_bin.sv
// Inverse 7-segment decoder: maps an active-low segment pattern back to its 0-F value.
module seg7_to_bin
    import seg7_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] val,
    output logic       hit,
    output logic       blank
);

    always_comb begin
        val   = '0;
        hit   = 1'b0;
        blank = (pat == SEG7_BLANK);
        for (int i = 0; i < 16; i++) begin
            if (pat == SEG7_PAT[i]) begin
                val = 4'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_readback.sv
// Recovers the value shown on an active-low 7-segment bus, checks 0..9 stepping and step period.
// Optional SEG7_RB_ERRCNT_EN adds a saturating error counter output (err_cnt).
module seg7_readback
    import seg7_pkg::*;
#(
    parameter int FREQ       = 50_000_000,
    parameter int STABLE_CYC = 1000,
    parameter int PERIOD_W   = $clog2(2*FREQ+1)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [7:0]          hex_in,
    output logic [3:0]          digit,
    output logic                digit_vld,
    output logic                pat_err,
    output logic                seq_err,
    output logic [PERIOD_W-1:0] period
`ifdef SEG7_RB_ERRCNT_EN
    ,
    output logic [7:0]          err_cnt
`endif
);

    localparam int                 STAB_W   = $clog2(STABLE_CYC+1);
    localparam logic [STAB_W-1:0]  STAB_MAX = STAB_W'(STABLE_CYC);
    localparam logic [PERIOD_W-1:0] GAP_MAX = '1;

    function automatic logic [3:0] succ10(input logic [3:0] d);
        int s;
        s = int'(d) + 1;
        return 4'(s % 10);
    endfunction

    function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
        return (v == GAP_MAX) ? GAP_MAX : v + 1'b1;
    endfunction

    logic [7:0]          sync_p0, sync_p1;
    logic [6:0]          cand;
    logic [STAB_W-1:0]   stab_cnt;
    logic [PERIOD_W-1:0] gap_cnt;
    seg7_rb_state_t      state;
    logic                accept;
    logic [3:0]          dec_val;
    logic                dec_hit, dec_blank;
    logic                seq_bad, err_evt;
    logic                dp_unused;

    assign dp_unused = sync_p1[7];

    // Two-flop synchronizer, then a candidate register the stability counter compares against
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_p0  <= 8'hFF;
            sync_p1  <= 8'hFF;
            cand     <= SEG7_BLANK;
            stab_cnt <= '0;
        end else begin
            sync_p0 <= hex_in;
            sync_p1 <= sync_p0;
            cand    <= sync_p1[6:0];
            if (sync_p1[6:0] != cand)
                stab_cnt <= '0;
            else if (stab_cnt != STAB_MAX)
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Fires exactly once, on the sample that brings the counter to STABLE_CYC
    assign accept = (sync_p1[6:0] == cand) && (stab_cnt == STAB_MAX - 1'b1);

    seg7_to_bin u_dec (
        .pat   (cand),
        .val   (dec_val),
        .hit   (dec_hit),
        .blank (dec_blank)
    );

    assign seq_bad = (dec_val != succ10(digit));
    assign err_evt = accept && !dec_blank &&
                     (!dec_hit || (state == RUN && dec_val != digit && seq_bad));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= WAIT_FIRST;
            digit     <= '0;
            digit_vld <= 1'b0;
            pat_err   <= 1'b0;
            seq_err   <= 1'b0;
            period    <= '0;
            gap_cnt   <= '0;
        end else begin
            digit_vld <= 1'b0;
            pat_err   <= 1'b0;
            seq_err   <= 1'b0;
            if (state == RUN && gap_cnt != GAP_MAX)
                gap_cnt <= gap_cnt + 1'b1;
            if (accept && !dec_blank) begin
                if (!dec_hit) begin
                    pat_err <= 1'b1;
                end else if (state == WAIT_FIRST) begin
                    digit     <= dec_val;
                    digit_vld <= 1'b1;
                    gap_cnt   <= '0;
                    state     <= RUN;
                end else if (dec_val != digit) begin
                    digit     <= dec_val;
                    digit_vld <= 1'b1;
                    seq_err   <= seq_bad;
                    period    <= sat_inc(gap_cnt);
                    gap_cnt   <= '0;
                end
            end
        end
    end

`ifdef SEG7_RB_ERRCNT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            err_cnt <= '0;
        else if (err_evt && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 1'b1;
    end
`else
    logic err_evt_unused;
    assign err_evt_unused = err_evt;
`endif

endmodule

// File: tb/tb_seg7_readback.sv
// Directed self-checking bench for seg7_readback (FREQ=1000, STABLE_CYC=4).
module tb_seg7_readback;

    localparam int FREQ       = 1000;
    localparam int STABLE_CYC = 4;
    localparam int PW         = $clog2(2*FREQ+1);

    logic          clk = 1'b0;
    logic          n_rst;
    logic [7:0]    hex_in;
    logic [3:0]    digit;
    logic          digit_vld, pat_err, seq_err;
    logic [PW-1:0] period;
`ifdef SEG7_RB_ERRCNT_EN
    logic [7:0]    err_cnt;
`endif

    seg7_readback #(.FREQ(FREQ), .STABLE_CYC(STABLE_CYC)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .hex_in    (hex_in),
        .digit     (digit),
        .digit_vld (digit_vld),
        .pat_err   (pat_err),
        .seq_err   (seq_err),
        .period    (period)
`ifdef SEG7_RB_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   vld_cnt = 0, pat_cnt = 0, seq_cnt = 0, orphan = 0, overlap = 0;
    int   last_vld_cyc = 0, drive_cyc = 0;
    logic seq_at_vld = 1'b0;
    int   n_cmp = 0, n_bad = 0;
    int   v0, p0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (digit_vld) begin
            vld_cnt      <= vld_cnt + 1;
            last_vld_cyc <= cyc;
            seq_at_vld   <= seq_err;
        end
        if (pat_err) pat_cnt <= pat_cnt + 1;
        if (seq_err) seq_cnt <= seq_cnt + 1;
        if (seq_err && !digit_vld) orphan <= orphan + 1;
        if (pat_err && (digit_vld || seq_err)) overlap <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic [7:0] p, input int n);
        @(posedge clk);
        #1;
        hex_in    = p;
        drive_cyc = cyc;
        repeat (n-1) @(posedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digit"},  32'(digit),     0);
        check({tag, "_vld"},    32'(digit_vld), 0);
        check({tag, "_pat"},    32'(pat_err),   0);
        check({tag, "_seq"},    32'(seq_err),   0);
        check({tag, "_period"}, 32'(period),    0);
`ifdef SEG7_RB_ERRCNT_EN
        check({tag, "_errcnt"}, 32'(err_cnt),   0);
`endif
    endtask

    initial begin
        n_rst  = 1'b0;
        hex_in = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst");
        @(posedge clk);
        #1 n_rst = 1'b1;

        hold(8'hFF, 20);
        check("blank_idle", 32'(vld_cnt + pat_cnt), 0);

        // First accepted digit
        hold(8'hC0, 100);
        check("latency", 32'(last_vld_cyc - drive_cyc), 7);
        check("first_vld", 32'(vld_cnt), 1);
        check("first_digit", 32'(digit), 0);
        check("first_period", 32'(period), 0);
        check("first_seq", 32'(seq_cnt), 0);

        hold(8'hF9, 100);
        check("d1", 32'(digit), 1);
        check("p1", 32'(period), 100);
        hold(8'hA4, 100);
        check("d2", 32'(digit), 2);
        check("p2", 32'(period), 100);
        check("vld3", 32'(vld_cnt), 3);
        check("seq_none", 32'(seq_cnt), 0);

        // Wrap and skips
        hold(8'h90, 100);
        check("d9", 32'(digit), 9);
        check("seq_2to9", 32'(seq_at_vld), 1);
        hold(8'hC0, 100);
        check("d0_wrap", 32'(digit), 0);
        check("seq_9to0", 32'(seq_at_vld), 0);
        check("seqcnt_wrap", 32'(seq_cnt), 1);
        hold(8'hB0, 100);
        check("d3", 32'(digit), 3);
        hold(8'h92, 100);
        check("d5", 32'(digit), 5);
        check("seq_3to5", 32'(seq_at_vld), 1);
        check("seqcnt5", 32'(seq_cnt), 3);
        check("vld7", 32'(vld_cnt), 7);

        // Glitch, dp, blank and illegal pattern
        hold(8'hC0, 100);
        check("vld8", 32'(vld_cnt), 8);
        hold(8'hF9, 3);
        hold(8'hC0, 100);
        check("glitch_vld", 32'(vld_cnt), 8);
        check("glitch_digit", 32'(digit), 0);
        hold(8'h40, 100);
        check("dp_ignored", 32'(vld_cnt), 8);
        hold(8'h7F, 100);
        check("blank_vld", 32'(vld_cnt), 8);
        check("blank_pat", 32'(pat_cnt), 0);
        check("blank_digit", 32'(digit), 0);
        hold(8'h55, 100);
        check("bad_pat", 32'(pat_cnt), 1);
        check("bad_digit", 32'(digit), 0);
        check("bad_vld", 32'(vld_cnt), 8);
        hold(8'h88, 100);
        check("dA", 32'(digit), 10);
        check("seq_A", 32'(seq_at_vld), 1);
        hold(8'hF9, 100);
        check("dA_to_1", 32'(digit), 1);
        check("seq_A_to_1", 32'(seq_at_vld), 0);
        check("orphan_seq", 32'(orphan), 0);
        check("overlap", 32'(overlap), 0);

        // Reset mid-run
        hex_in = 8'hFF;
        @(posedge clk);
        #1 n_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("midrst");
        @(posedge clk);
        #1 n_rst = 1'b1;
        v0 = vld_cnt;
        p0 = pat_cnt;
        hold(8'hFF, 20);
        check("no_stale", 32'(vld_cnt + pat_cnt), 32'(v0 + p0));
        hold(8'hB0, 100);
        check("rst_vld", 32'(vld_cnt), 32'(v0 + 1));
        check("rst_digit", 32'(digit), 3);
        check("rst_seq", 32'(seq_at_vld), 0);
        check("rst_period", 32'(period), 0);

`ifdef SEG7_RB_ERRCNT_EN
        p0 = pat_cnt;
        for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 8'h55 : 8'h56, 8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("errcnt10", 32'(err_cnt), 10);
        for (int i = 0; i < 290; i++) hold((i % 2 == 0) ? 8'h55 : 8'h56, 8);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pat300", 32'(pat_cnt - p0), 300);
        check("errcnt_sat", 32'(err_cnt), 255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
